// File: rtl/parking_pkg.sv
// Shared types and constants for the parking ramp arbiter and the per-gate controllers.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_ENTRY = 2'd1,
        GRANT_EXIT  = 2'd2,
        CLEAR       = 2'd3
    } ramp_state_t;

    // Constants consumed by the gate controllers that sit below the arbiter
    localparam int         PASSWORD_DIGITS        = 4;
    localparam int         SENSOR_DEBOUNCE_CYCLES = 4;
    localparam logic [3:0] SENSOR_CLEAR_CODE      = 4'hA;

endpackage

// File: rtl/parking_ramp_arbiter_checker.sv
// Invariant monitor: occupancy never wraps and at most one grant is ever high.
module parking_ramp_arbiter_checker #(
    parameter int CAPACITY = 8,
    parameter int OW       = 4,
    parameter int N_ENTRY  = 2,
    parameter int N_EXIT   = 2
) (
    input logic               clk,
    input logic               reset,
    input logic               inc,
    input logic               dec,
    input logic [OW-1:0]      occupancy,
    input logic [N_ENTRY-1:0] entry_gnt,
    input logic [N_EXIT-1:0]  exit_gnt
);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(inc && occupancy == OW'(CAPACITY)));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(dec && occupancy == OW'(0)));

    a_single_grant: assert property (@(posedge clk) disable iff (reset)
        $onehot0({entry_gnt, exit_gnt}));

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward, wrapping, and
// returns the first asserted request as a one-hot vector and an index.
module rr_arbiter
    import parking_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Priority search starting one past the last winner
    always_comb begin
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand_s      = IW'((int'(ptr) + i) % N);
            hit_s       = en & req[cand_s] & ~valid;
            idx         = hit_s ? cand_s : idx;
            gnt[cand_s] = gnt[cand_s] | hit_s;
            valid       = valid | hit_s;
        end
    end

endmodule

// File: rtl/parking_ramp_arbiter.sv
// Single-lane parking ramp arbiter: grants the ramp to one gate at a time,
// exits before entries, and tracks lot occupancy.
module parking_ramp_arbiter
    import parking_pkg::*;
#(
    parameter  int N_ENTRY  = 2,
    parameter  int N_EXIT   = 2,
    parameter  int CAPACITY = 8,
    parameter  int TIMEOUT  = 16,
    localparam int OW       = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_ENTRY-1:0] entry_req,
    input  logic [N_EXIT-1:0]  exit_req,
    input  logic               pass_done,
    output logic [N_ENTRY-1:0] entry_gnt,
    output logic [N_EXIT-1:0]  exit_gnt,
    output logic [OW-1:0]      occupancy,
    output logic               full,
    output logic               empty,
    output logic               ramp_busy,
    output logic               timeout_err
);

    localparam int EIW = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
    localparam int XIW = (N_EXIT > 1) ? $clog2(N_EXIT) : 1;
    localparam int CW  = $clog2(TIMEOUT);

    ramp_state_t    state_r, state_s;
    logic [EIW-1:0] entry_ptr_r, entry_ptr_s;
    logic [XIW-1:0] exit_ptr_r, exit_ptr_s;
    logic [OW-1:0]  occ_r, occ_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           terr_r, terr_s;

    logic [N_ENTRY-1:0] entry_win_s;
    logic [N_EXIT-1:0]  exit_win_s;
    logic [EIW-1:0]     entry_idx_s;
    logic [XIW-1:0]     exit_idx_s;
    logic               entry_valid_s, exit_valid_s;
    logic               inc_s, dec_s;

    rr_arbiter #(.N(N_EXIT)) u_exit_arb (
        .req   (exit_req),
        .ptr   (exit_ptr_r),
        .en    (occ_r != OW'(0)),
        .gnt   (exit_win_s),
        .idx   (exit_idx_s),
        .valid (exit_valid_s)
    );

    rr_arbiter #(.N(N_ENTRY)) u_entry_arb (
        .req   (entry_req),
        .ptr   (entry_ptr_r),
        .en    (occ_r != OW'(CAPACITY)),
        .gnt   (entry_win_s),
        .idx   (entry_idx_s),
        .valid (entry_valid_s)
    );

    // State, pointers, occupancy, timeout counter and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            entry_ptr_r <= EIW'(N_ENTRY - 1);
            exit_ptr_r  <= XIW'(N_EXIT - 1);
            occ_r       <= '0;
            cnt_r       <= '0;
            terr_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            entry_ptr_r <= entry_ptr_s;
            exit_ptr_r  <= exit_ptr_s;
            occ_r       <= occ_s;
            cnt_r       <= cnt_s;
            terr_r      <= terr_s;
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until pass_done or timeout
    always_comb begin
        state_s     = state_r;
        entry_ptr_s = entry_ptr_r;
        exit_ptr_s  = exit_ptr_r;
        occ_s       = occ_r;
        cnt_s       = cnt_r;
        terr_s      = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (exit_valid_s) begin
                    state_s    = GRANT_EXIT;
                    exit_ptr_s = exit_idx_s;
                end else if (entry_valid_s) begin
                    state_s     = GRANT_ENTRY;
                    entry_ptr_s = entry_idx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_ENTRY, GRANT_EXIT: begin
                if (pass_done) begin
                    state_s = CLEAR;
                    occ_s   = (state_r == GRANT_ENTRY) ? occ_r + OW'(1) : occ_r - OW'(1);
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    state_s = CLEAR;
                    terr_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            CLEAR: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Moore grant decode; the class pointer doubles as the registered winner index
    always_comb begin
        entry_gnt = '0;
        exit_gnt  = '0;
        if (state_r == GRANT_ENTRY) begin
            entry_gnt[entry_ptr_r] = 1'b1;
        end else if (state_r == GRANT_EXIT) begin
            exit_gnt[exit_ptr_r] = 1'b1;
        end else begin
            entry_gnt = '0;
        end
    end

    assign occupancy   = occ_r;
    assign full        = (occ_r == OW'(CAPACITY));
    assign empty       = (occ_r == OW'(0));
    assign ramp_busy   = (state_r == GRANT_ENTRY) || (state_r == GRANT_EXIT);
    assign timeout_err = terr_r;
    assign inc_s       = (state_r == GRANT_ENTRY) && pass_done;
    assign dec_s       = (state_r == GRANT_EXIT) && pass_done;

    parking_ramp_arbiter_checker #(
        .CAPACITY (CAPACITY),
        .OW       (OW),
        .N_ENTRY  (N_ENTRY),
        .N_EXIT   (N_EXIT)
    ) u_checker (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_s),
        .dec       (dec_s),
        .occupancy (occ_r),
        .entry_gnt (entry_gnt),
        .exit_gnt  (exit_gnt)
    );

endmodule

// File: tb/tb_parking_ramp_arbiter.sv
// Directed bench for parking_ramp_arbiter with default parameters (2/2/8/16).
module tb_parking_ramp_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] entry_req;
    logic [1:0] exit_req;
    logic       pass_done;
    logic [1:0] entry_gnt;
    logic [1:0] exit_gnt;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;
    logic       ramp_busy;
    logic       timeout_err;

    int checks_r = 0;
    int errors_r = 0;

    parking_ramp_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .pass_done   (pass_done),
        .entry_gnt   (entry_gnt),
        .exit_gnt    (exit_gnt),
        .occupancy   (occupancy),
        .full        (full),
        .empty       (empty),
        .ramp_busy   (ramp_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full entry transaction; returns with the FSM back in IDLE
    task automatic do_entry(input logic [1:0] req);
        entry_req = req;
        tick();
        entry_req = 2'b00;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        entry_req = 2'b00;
        exit_req  = 2'b00;
        pass_done = 1'b0;
        tick();
        tick();
        check_val("rst_entry_gnt", 32'(entry_gnt), 32'd0);
        check_val("rst_exit_gnt", 32'(exit_gnt), 32'd0);
        check_val("rst_occ", 32'(occupancy), 32'd0);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_busy", 32'(ramp_busy), 32'd0);
        check_val("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        // Round-robin between two entrances
        entry_req = 2'b11;
        tick();
        check_val("rr_first_gnt", 32'(entry_gnt), 32'd1);
        check_val("rr_busy", 32'(ramp_busy), 32'd1);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_val("rr_clear_gnt", 32'(entry_gnt), 32'd0);
        check_val("rr_occ1", 32'(occupancy), 32'd1);
        check_val("rr_clear_busy", 32'(ramp_busy), 32'd0);
        tick();
        check_val("rr_idle_gnt", 32'(entry_gnt), 32'd0);
        tick();
        check_val("rr_second_gnt", 32'(entry_gnt), 32'd2);
        entry_req = 2'b00;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_val("rr_occ2", 32'(occupancy), 32'd2);
        tick();
        do_entry(2'b01);
        check_val("occ3", 32'(occupancy), 32'd3);

        // Exit beats a simultaneous entry
        entry_req = 2'b01;
        exit_req  = 2'b10;
        tick();
        check_val("prio_exit_gnt", 32'(exit_gnt), 32'd2);
        check_val("prio_entry_gnt", 32'(entry_gnt), 32'd0);
        exit_req  = 2'b00;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_val("prio_occ2", 32'(occupancy), 32'd2);
        tick();
        tick();
        check_val("prio_then_entry", 32'(entry_gnt), 32'd1);
        entry_req = 2'b00;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_val("prio_occ3", 32'(occupancy), 32'd3);
        tick();

        // Fill the lot, entry must wait until an exit frees a space
        for (int i = 0; i < 5; i++) do_entry(2'b01);
        check_val("fill_occ", 32'(occupancy), 32'd8);
        check_val("fill_full", 32'(full), 32'd1);
        entry_req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("full_no_gnt", 32'(entry_gnt), 32'd0);
        end
        exit_req = 2'b01;
        tick();
        check_val("full_exit_gnt", 32'(exit_gnt), 32'd1);
        exit_req  = 2'b00;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_val("full_occ7", 32'(occupancy), 32'd7);
        check_val("full_cleared", 32'(full), 32'd0);
        tick();
        check_val("full_wait_gnt", 32'(entry_gnt), 32'd0);
        tick();
        check_val("full_entry_gnt", 32'(entry_gnt), 32'd1);
        entry_req = 2'b00;

        // Reset clears the lot; exits on an empty lot are ignored
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        exit_req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("empty_no_gnt", 32'(exit_gnt), 32'd0);
            check_val("empty_flag", 32'(empty), 32'd1);
        end
        exit_req = 2'b00;

        // Timeout: grant held exactly 16 cycles, then a one-cycle error pulse
        entry_req = 2'b01;
        tick();
        entry_req = 2'b00;
        check_val("to_gnt_c1", 32'(entry_gnt), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_val("to_gnt_held", 32'(entry_gnt), 32'd1);
            check_val("to_no_terr", 32'(timeout_err), 32'd0);
        end
        tick();
        check_val("to_gnt_drop", 32'(entry_gnt), 32'd0);
        check_val("to_terr", 32'(timeout_err), 32'd1);
        check_val("to_occ", 32'(occupancy), 32'd0);
        tick();
        check_val("to_terr_pulse", 32'(timeout_err), 32'd0);

        // pass_done in the 16th cycle wins over the timeout
        entry_req = 2'b01;
        tick();
        entry_req = 2'b00;
        for (int i = 0; i < 15; i++) tick();
        check_val("late_gnt_c16", 32'(entry_gnt), 32'd1);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_val("late_no_terr", 32'(timeout_err), 32'd0);
        check_val("late_occ", 32'(occupancy), 32'd1);
        check_val("late_gnt_drop", 32'(entry_gnt), 32'd0);
        tick();

        // Reset mid-grant with five cars parked
        for (int i = 0; i < 4; i++) do_entry(2'b01);
        check_val("mid_occ5", 32'(occupancy), 32'd5);
        entry_req = 2'b01;
        tick();
        check_val("mid_gnt", 32'(entry_gnt), 32'd1);
        entry_req = 2'b00;
        reset     = 1'b1;
        tick();
        check_val("mid_rst_gnt", 32'({entry_gnt, exit_gnt}), 32'd0);
        check_val("mid_rst_occ", 32'(occupancy), 32'd0);
        check_val("mid_rst_empty", 32'(empty), 32'd1);
        check_val("mid_rst_busy", 32'(ramp_busy), 32'd0);
        reset     = 1'b0;
        entry_req = 2'b11;
        tick();
        check_val("post_rst_gnt", 32'(entry_gnt), 32'd1);
        entry_req = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
